// File: rtl/intercore_lock_arbiter_pkg.sv
// rtl/intercore_lock_arbiter_pkg.sv - SR register map, data-field positions and request decode
// shared by the spinlock bank and its slots.
package intercore_lock_arbiter_pkg;

  localparam int RW        = 16;
  localparam int MAX_LOCKS = 8;
  localparam int MASK_W    = 8;
  localparam int IDX_LSB   = 0;
  localparam int IDX_W     = 3;
  localparam int WAIT_BIT  = 15;
  localparam int FORCE_BIT = 14;
  localparam int OK_BIT    = 8;
  localparam int ERR_BIT   = 9;
  localparam int WT_BIT    = 10;

  localparam logic [RW-1:0] SREG_ACQ  = RW'(4'hC);
  localparam logic [RW-1:0] SREG_REL  = RW'(4'hD);
  localparam logic [RW-1:0] SREG_STAT = RW'(4'hE);

  typedef struct packed {
    logic             acq;
    logic             rel;
    logic             wt;
    logic             frc;
    logic             idx_ok;
    logic [IDX_W-1:0] idx;
  } sr_req_t;

  function automatic sr_req_t decode_req(input logic we, input logic [RW-1:0] addr,
                                         input logic [RW-1:0] data, input int nlocks);
    sr_req_t r;
    r.acq    = we && (addr == SREG_ACQ);
    r.rel    = we && (addr == SREG_REL);
    r.wt     = data[WAIT_BIT];
    r.frc    = data[FORCE_BIT];
    r.idx    = data[IDX_LSB +: IDX_W];
    r.idx_ok = (int'(r.idx) < nlocks);
    return r;
  endfunction

  function automatic logic [RW-1:0] pack_stat(input logic [MASK_W-1:0] mask, input logic ok,
                                              input logic err, input logic wt);
    logic [RW-1:0] s;
    s              = '0;
    s[MASK_W-1:0]  = mask;
    s[OK_BIT]      = ok;
    s[ERR_BIT]     = err;
    s[WT_BIT]      = wt;
    return s;
  endfunction

endpackage

// File: rtl/intercore_lock_slot.sv
// rtl/intercore_lock_slot.sv - one spinlock: ownership, waiter bits and same-cycle
// release-then-acquire resolution for two cores.
module intercore_lock_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] acq,
  input  logic [1:0] rel,
  input  logic [1:0] wt,
  input  logic       frc,
  input  logic       prio,
  output logic [1:0] owned,
  output logic [1:0] waiting,
  output logic [1:0] wake,
  output logic [1:0] grant,
  output logic [1:0] deny,
  output logic       tie
);

  logic       held_q, owner_q;
  logic [1:0] waiter_q;
  logic       held_d, owner_d;
  logic [1:0] waiter_d;
  logic [1:0] rel_hit;
  logic       freed, free_pr;

  // Releases are judged against the state at the start of the cycle; acquires
  // then see the post-release view (free_pr).
  always_comb begin
    rel_hit[0] = rel[0] && ((held_q && !owner_q) || frc);
    rel_hit[1] = rel[1] && held_q && owner_q;
    freed      = held_q && (rel_hit != 2'b00);
    free_pr    = !held_q || freed;
    tie        = free_pr && (acq == 2'b11);
    grant[0]   = acq[0] && (free_pr ? (!tie || !prio) : !owner_q);
    grant[1]   = acq[1] && (free_pr ? (!tie || prio) : owner_q);
    deny       = acq & ~grant;
    wake       = freed ? (waiter_q & ~acq) : 2'b00;
    held_d     = !free_pr || (grant != 2'b00);
    owner_d    = free_pr ? grant[1] : owner_q;
    waiter_d   = (freed ? 2'b00 : waiter_q) | (deny & wt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q   <= 1'b0;
      owner_q  <= 1'b0;
      waiter_q <= 2'b00;
    end else begin
      held_q   <= held_d;
      owner_q  <= owner_d;
      waiter_q <= waiter_d;
    end
  end

  assign owned   = {held_q && owner_q, held_q && !owner_q};
  assign waiting = waiter_q;

endmodule

// File: rtl/intercore_lock_arbiter.sv
// rtl/intercore_lock_arbiter.sv - hardware spinlock bank for core0/core1 on their SR buses:
// address decode, round-robin tie break, result registers, wake pulses and status read.
module intercore_lock_arbiter
  import intercore_lock_arbiter_pkg::*;
#(
  parameter int NLOCKS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [RW-1:0] c0_sr_bus_addr,
  input  logic [RW-1:0] c0_sr_bus_data_o,
  output logic [RW-1:0] c0_sr_bus_data_i,
  input  logic          c0_sr_bus_we,
  input  logic [RW-1:0] c1_sr_bus_addr,
  input  logic [RW-1:0] c1_sr_bus_data_o,
  output logic [RW-1:0] c1_sr_bus_data_i,
  input  logic          c1_sr_bus_we,
  output logic          c0_lock_irq,
  output logic          c1_lock_irq
);

  sr_req_t req [2];

  logic [1:0] slot_owned   [MAX_LOCKS];
  logic [1:0] slot_waiting [MAX_LOCKS];
  logic [1:0] slot_wake    [MAX_LOCKS];
  logic [1:0] slot_grant   [MAX_LOCKS];
  logic [1:0] slot_deny    [MAX_LOCKS];
  logic       slot_tie     [MAX_LOCKS];

  logic [1:0][MASK_W-1:0] own_mask;
  logic [1:0] wt_any, grant_any, deny_any, wake_any, rel_fail;
  logic       tie_any;
  logic [1:0] ok_q, err_q, irq_q;
  logic       rr_prio;

  assign req[0] = decode_req(c0_sr_bus_we, c0_sr_bus_addr, c0_sr_bus_data_o, NLOCKS);
  assign req[1] = decode_req(c1_sr_bus_we, c1_sr_bus_addr, c1_sr_bus_data_o, NLOCKS);

  for (genvar i = 0; i < MAX_LOCKS; i++) begin : g_slot
    if (i < NLOCKS) begin : g_live
      logic [1:0] slot_acq, slot_rel;

      always_comb begin
        for (int k = 0; k < 2; k++) begin
          slot_acq[k] = req[k].acq && req[k].idx_ok && (req[k].idx == IDX_W'(i));
          slot_rel[k] = req[k].rel && req[k].idx_ok && (req[k].idx == IDX_W'(i));
        end
      end

      intercore_lock_slot u_slot (
        .clk     (i_clk),
        .rst     (i_rst),
        .acq     (slot_acq),
        .rel     (slot_rel),
        .wt      ({req[1].wt, req[0].wt}),
        .frc     (req[0].frc),
        .prio    (rr_prio),
        .owned   (slot_owned[i]),
        .waiting (slot_waiting[i]),
        .wake    (slot_wake[i]),
        .grant   (slot_grant[i]),
        .deny    (slot_deny[i]),
        .tie     (slot_tie[i])
      );
    end else begin : g_absent
      assign slot_owned[i]   = 2'b00;
      assign slot_waiting[i] = 2'b00;
      assign slot_wake[i]    = 2'b00;
      assign slot_grant[i]   = 2'b00;
      assign slot_deny[i]    = 2'b00;
      assign slot_tie[i]     = 1'b0;
    end
  end

  // Each core targets at most one slot per cycle, so OR-reducing across slots
  // yields that core's own grant/deny.
  always_comb begin
    own_mask  = '0;
    wt_any    = 2'b00;
    grant_any = 2'b00;
    deny_any  = 2'b00;
    wake_any  = 2'b00;
    tie_any   = 1'b0;
    for (int i = 0; i < MAX_LOCKS; i++) begin
      for (int k = 0; k < 2; k++) begin
        own_mask[k][i] = slot_owned[i][k];
        wt_any[k]      = wt_any[k] | slot_waiting[i][k];
        grant_any[k]   = grant_any[k] | slot_grant[i][k];
        deny_any[k]    = deny_any[k] | slot_deny[i][k];
        wake_any[k]    = wake_any[k] | slot_wake[i][k];
      end
      tie_any = tie_any | slot_tie[i];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rel_fail[k] = !req[k].idx_ok ||
                    !(own_mask[k][req[k].idx] || ((k == 0) && req[k].frc));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ok_q    <= 2'b00;
      err_q   <= 2'b00;
      irq_q   <= 2'b00;
      rr_prio <= 1'b0;
    end else begin
      irq_q <= wake_any;
      // The tie loser becomes the favoured core for the next tie.
      if (tie_any) begin
        rr_prio <= ~rr_prio;
      end
      for (int k = 0; k < 2; k++) begin
        if (req[k].acq) begin
          ok_q[k]  <= grant_any[k] && !deny_any[k];
          err_q[k] <= !req[k].idx_ok;
        end else if (req[k].rel && rel_fail[k]) begin
          err_q[k] <= 1'b1;
        end
      end
    end
  end

  assign c0_lock_irq = irq_q[0];
  assign c1_lock_irq = irq_q[1];

  assign c0_sr_bus_data_i = (c0_sr_bus_addr == SREG_STAT) ?
                            pack_stat(own_mask[0], ok_q[0], err_q[0], wt_any[0]) : '0;
  assign c1_sr_bus_data_i = (c1_sr_bus_addr == SREG_STAT) ?
                            pack_stat(own_mask[1], ok_q[1], err_q[1], wt_any[1]) : '0;

endmodule

// File: tb/tb_intercore_lock_arbiter.sv
// tb/tb_intercore_lock_arbiter.sv - directed and randomized checks of the spinlock bank
// against a lock-table reference model.
module tb_intercore_lock_arbiter;
  import intercore_lock_arbiter_pkg::*;

  localparam int NL = 6;
  localparam logic [15:0] ACQ  = 16'hC;
  localparam logic [15:0] REL  = 16'hD;
  localparam logic [15:0] STAT = 16'hE;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
  logic [15:0] q0, q1;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        irq0, irq1;

  always #5 i_clk = ~i_clk;

  intercore_lock_arbiter #(.NLOCKS(NL)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .c0_sr_bus_addr   (a0),
    .c0_sr_bus_data_o (d0),
    .c0_sr_bus_data_i (q0),
    .c0_sr_bus_we     (we0),
    .c1_sr_bus_addr   (a1),
    .c1_sr_bus_data_o (d1),
    .c1_sr_bus_data_i (q1),
    .c1_sr_bus_we     (we1),
    .c0_lock_irq      (irq0),
    .c1_lock_irq      (irq1)
  );

  // Reference model: lock table (-1 = free), waiter flags, per-core results.
  int own [NL];
  bit wt  [NL][2];
  bit m_ok [2];
  bit m_err [2];
  bit m_irq [2];
  int prio;

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      own[l] = -1;
      wt[l][0] = 1'b0;
      wt[l][1] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      m_ok[k] = 1'b0;
      m_err[k] = 1'b0;
      m_irq[k] = 1'b0;
    end
    prio = 0;
  endtask

  task automatic model_step(input bit w0, input logic [15:0] ad0, input logic [15:0] dd0,
                            input bit w1, input logic [15:0] ad1, input logic [15:0] dd1);
    bit acq [2], rel [2], wb [2], fb [2], vld [2], succ [2];
    bit freed [NL];
    int idx [2];
    int l, win, lose;
    acq[0] = w0 && ad0 == ACQ;  rel[0] = w0 && ad0 == REL;
    acq[1] = w1 && ad1 == ACQ;  rel[1] = w1 && ad1 == REL;
    idx[0] = int'(dd0[2:0]);    idx[1] = int'(dd1[2:0]);
    wb[0] = dd0[15]; wb[1] = dd1[15];
    fb[0] = dd0[14]; fb[1] = dd1[14];
    for (int k = 0; k < 2; k++) vld[k] = idx[k] < NL;
    for (int m = 0; m < NL; m++) freed[m] = 1'b0;
    m_irq[0] = 1'b0;
    m_irq[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      succ[k] = 1'b0;
      if (rel[k]) begin
        succ[k] = vld[k] && (own[idx[k]] == k || (k == 0 && fb[k]));
        if (!succ[k]) m_err[k] = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++)
      if (rel[k] && succ[k] && own[idx[k]] != -1) freed[idx[k]] = 1'b1;
    for (int m = 0; m < NL; m++) begin
      if (freed[m]) begin
        own[m] = -1;
        for (int k = 0; k < 2; k++) begin
          if (wt[m][k]) begin
            wt[m][k] = 1'b0;
            if (!(acq[k] && vld[k] && idx[k] == m)) m_irq[k] = 1'b1;
          end
        end
      end
    end
    if (acq[0] && acq[1] && vld[0] && vld[1] && idx[0] == idx[1] && own[idx[0]] == -1) begin
      l = idx[0];
      win = prio;
      lose = 1 - prio;
      own[l] = win;
      m_ok[win] = 1'b1;
      m_err[win] = 1'b0;
      m_ok[lose] = 1'b0;
      m_err[lose] = 1'b0;
      if (wb[lose]) wt[l][lose] = 1'b1;
      prio = lose;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (acq[k]) begin
          if (!vld[k]) begin
            m_ok[k] = 1'b0;
            m_err[k] = 1'b1;
          end else begin
            m_err[k] = 1'b0;
            l = idx[k];
            if (own[l] == -1) begin
              own[l] = k;
              m_ok[k] = 1'b1;
            end else if (own[l] == k) begin
              m_ok[k] = 1'b1;
            end else begin
              m_ok[k] = 1'b0;
              if (wb[k]) wt[l][k] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_stat(input int k);
    logic [15:0] s;
    bit anyw;
    s = '0;
    anyw = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (own[l] == k) s[l] = 1'b1;
      if (wt[l][k]) anyw = 1'b1;
    end
    s[8] = m_ok[k];
    s[9] = m_err[k];
    s[10] = anyw;
    return s;
  endfunction

  task automatic check_all(input string tag);
    we0 = 1'b0; we1 = 1'b0;
    a0 = STAT;  a1 = STAT;
    #1;
    chk({tag, ":c0_stat"}, q0, exp_stat(0));
    chk({tag, ":c1_stat"}, q1, exp_stat(1));
    chk({tag, ":c0_irq"}, 16'(irq0), 16'(m_irq[0]));
    chk({tag, ":c1_irq"}, 16'(irq1), 16'(m_irq[1]));
  endtask

  task automatic step(input bit w0, input logic [15:0] ad0, input logic [15:0] dd0,
                      input bit w1, input logic [15:0] ad1, input logic [15:0] dd1);
    we0 = w0; a0 = ad0; d0 = dd0;
    we1 = w1; a1 = ad1; d1 = dd1;
    @(posedge i_clk);
    model_step(w0, ad0, dd0, w1, ad1, dd1);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    i_rst = 1'b1;
    model_reset();
    check_all({tag, ":during"});
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_all({tag, ":exit"});
  endtask

  initial begin
    logic [15:0] d;
    int idx, r;
    bit w;
    logic [15:0] ad;

    repeat (2) @(posedge i_clk);
    #1;
    apply_reset("t1");
    chk("t1_c0_zero", q0, 16'h0000);
    chk("t1_c1_zero", q1, 16'h0000);

    step(1, ACQ, 16'h0003, 0, STAT, 16'h0);
    check_all("t2");
    chk("t2_c0_stat", q0, 16'h0108);
    chk("t2_c1_mask", {8'h0, q1[7:0]}, 16'h0000);
    a0 = REL;
    #1;
    chk("t2_other_addr", q0, 16'h0000);

    step(0, STAT, 16'h0, 1, ACQ, 16'h8003);
    check_all("t3a");
    chk("t3_c1_okwt", {13'h0, q1[10:8]}, 16'h0004);
    step(1, REL, 16'h0003, 0, STAT, 16'h0);
    check_all("t3b");
    chk("t3_irq_on", 16'(irq1), 16'h0001);
    chk("t3_c1_wt_clr", 16'(q1[10]), 16'h0000);
    step(0, STAT, 16'h0, 0, STAT, 16'h0);
    check_all("t3c");
    chk("t3_irq_off", 16'(irq1), 16'h0000);

    apply_reset("t4r");
    step(1, ACQ, 16'h0005, 1, ACQ, 16'h0005);
    check_all("t4a");
    chk("t4_c0_win", q0, 16'h0120);
    chk("t4_c1_ok", 16'(q1[8]), 16'h0000);
    step(1, REL, 16'h0005, 1, REL, 16'h0005);
    check_all("t4b");
    step(1, ACQ, 16'h0005, 1, ACQ, 16'h0005);
    check_all("t4c");
    chk("t4_c1_win", {8'h0, q1[7:0]}, 16'h0020);

    step(1, ACQ, 16'h0002, 0, STAT, 16'h0);
    check_all("t5a");
    step(1, REL, 16'h0002, 1, ACQ, 16'h0002);
    check_all("t5b");
    chk("t5_c1_own2", {13'h0, q1[2], q1[8], irq1}, 16'h0006);
    chk("t5_c0_irq", 16'(irq0), 16'h0000);

    step(1, ACQ, 16'h0004, 0, STAT, 16'h0);
    check_all("t6a");
    step(0, STAT, 16'h0, 1, REL, 16'h0004);
    check_all("t6b");
    chk("t6_c1_err", 16'(q1[9]), 16'h0001);
    chk("t6_c0_keeps4", 16'(q0[4]), 16'h0001);
    step(1, REL, 16'h4005, 0, STAT, 16'h0);
    check_all("t6c");
    chk("t6_force_free", 16'(q1[5]), 16'h0000);
    step(1, ACQ, 16'h0007, 0, STAT, 16'h0);
    check_all("t6d");
    chk("t6_bad_idx", {14'h0, q0[9:8]}, 16'h0002);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_rst_c0_mask", {8'h0, q0[7:0]}, 16'h0000);
    chk("t6_rst_c1_mask", {8'h0, q1[7:0]}, 16'h0000);
    apply_reset("t6r");

    for (int it = 0; it < 400; it++) begin
      logic [15:0] dd [2];
      logic [15:0] aa [2];
      bit ww [2];
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 9);
        idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 7);
        d = 16'($urandom);
        d[2:0] = 3'(idx);
        d[15] = ($urandom_range(0, 1) == 1);
        d[14] = ($urandom_range(0, 3) == 0);
        w = 1'b1;
        if (r <= 3) ad = ACQ;
        else if (r <= 6) ad = REL;
        else if (r == 7) ad = STAT;
        else if (r == 8) ad = 16'h0003;
        else begin
          ad = ACQ;
          w = 1'b0;
        end
        dd[k] = d;
        aa[k] = ad;
        ww[k] = w;
      end
      step(ww[0], aa[0], dd[0], ww[1], aa[1], dd[1]);
      check_all($sformatf("rnd%0d", it));
      if (it == 200) apply_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
